// File: rtl/deadtime_gate_driver_if.sv
// deadtime_gate_driver_if: enable/polarity request in, gate commands and status out
//   master: drives i_enable, i_sigma; observes o_gate_h, o_gate_l, o_sigma, o_busy, o_switch_count
//   slave : the driver side of the same signals
interface deadtime_gate_driver_if;
   logic        i_enable;
   logic        i_sigma;
   logic        o_gate_h;
   logic        o_gate_l;
   logic        o_sigma;
   logic        o_busy;
   logic [15:0] o_switch_count;
   modport master (output i_enable, i_sigma, input o_gate_h, o_gate_l, o_sigma, o_busy, o_switch_count);
   modport slave (input i_enable, i_sigma, output o_gate_h, o_gate_l, o_sigma, o_busy, o_switch_count);
endinterface

// File: rtl/deadtime_gate_driver.sv
// deadtime_gate_driver: half-bridge gate sequencer with dead time and minimum dwell
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous active-high reset
//   bus.i_enable   : 1 = may conduct, 0 = force both gates off next edge
//   bus.i_sigma    : requested polarity (1 = high side, 0 = low side)
//   bus.o_gate_h/l : registered gate commands, never both high
//   bus.o_sigma    : polarity of the last conducting state entered
//   bus.o_busy     : in dead time or dwell not yet met
//   bus.o_switch_count : entries into HIGH/LOW, wrapping 16-bit
module deadtime_gate_driver #(
   parameter int DEAD_TIME = 4,
   parameter int MIN_DWELL = 20
) (
   input logic i_clk,
   input logic i_reset,
   deadtime_gate_driver_if.slave bus
);
   typedef enum logic [1:0] {OFF, DEAD, HIGH, LOW} state_t;
   state_t state_q, state_d;
   logic target_q, target_d;
   logic [31:0] dead_q, dead_d, dwell_q, dwell_d;
   logic sigma_q, sigma_d;
   logic [15:0] count_q, count_d;
   logic gate_h_q, gate_l_q, busy_q, busy_d;
   logic dwell_met, enter;
   assign dwell_met = dwell_q >= 32'(MIN_DWELL);
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      dead_d   = dead_q;
      dwell_d  = dwell_q;
      if (!bus.i_enable) begin
         state_d = OFF;
         dead_d  = '0;
         dwell_d = '0;
      end else if (state_q == OFF) begin
         state_d  = DEAD;
         target_d = bus.i_sigma;
         dead_d   = '0;
      end else if (state_q == DEAD) begin
         if (dead_q == 32'(DEAD_TIME - 1)) begin
            state_d = target_q ? HIGH : LOW;
            dwell_d = '0;
         end else
            dead_d = dead_q + 32'd1;
      end else if (dwell_met && (bus.i_sigma != (state_q == HIGH))) begin
         // a request held off during dwell is still on i_sigma here, so it is taken now
         state_d  = DEAD;
         target_d = bus.i_sigma;
         dead_d   = '0;
      end else
         dwell_d = dwell_met ? dwell_q : dwell_q + 32'd1;
      enter   = (state_q == DEAD) && (state_d == HIGH || state_d == LOW);
      sigma_d = enter ? target_q : sigma_q;
      count_d = count_q + 16'(enter);
      busy_d  = (state_d == DEAD) || ((state_d == HIGH || state_d == LOW) && dwell_d < 32'(MIN_DWELL));
   end
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= OFF;
         target_q <= 1'b0;
         dead_q   <= '0;
         dwell_q  <= '0;
         sigma_q  <= 1'b0;
         count_q  <= '0;
         gate_h_q <= 1'b0;
         gate_l_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         dead_q   <= dead_d;
         dwell_q  <= dwell_d;
         sigma_q  <= sigma_d;
         count_q  <= count_d;
         gate_h_q <= state_d == HIGH;
         gate_l_q <= state_d == LOW;
         busy_q   <= busy_d;
      end
   end
   assign bus.o_gate_h       = gate_h_q;
   assign bus.o_gate_l       = gate_l_q;
   assign bus.o_sigma        = sigma_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_switch_count = count_q;
endmodule

// File: tb/tb_deadtime_gate_driver.sv
// tb_deadtime_gate_driver: directed vector table plus corner-case sequences
module tb_deadtime_gate_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   deadtime_gate_driver_if bus ();
   deadtime_gate_driver #(.DEAD_TIME(4), .MIN_DWELL(10)) dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));
   typedef struct {
      logic en;
      logic sig;
      int n;
      logic gh;
      logic gl;
      logic sg;
      logic bz;
      logic [15:0] cnt;
   } vec_t;
   vec_t vecs[$];
   int checks = 0;
   int errors = 0;
   logic [19:0] obs;
   assign obs = {bus.o_gate_h, bus.o_gate_l, bus.o_sigma, bus.o_busy, bus.o_switch_count};
   task automatic add(input logic en, input logic sig, input int n, input logic gh, input logic gl,
                      input logic sg, input logic bz, input logic [15:0] cnt);
      vec_t v;
      v.en = en; v.sig = sig; v.n = n; v.gh = gh; v.gl = gl; v.sg = sg; v.bz = bz; v.cnt = cnt;
      vecs.push_back(v);
   endtask
   task automatic chk_out(input string name, input logic [19:0] got, input logic [19:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: gh/gl/sigma/busy/count got %b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d", name,
                  got[19], got[18], got[17], got[16], got[15:0], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
      end
   endtask
   task automatic chk_cond(input string name, input bit ok, input int got, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask
   int lvl, prev, run, rises, delta;
   bit started;
   logic [15:0] c0;
   initial begin
      // en sig n | gh gl sg busy count   (DEAD_TIME=4, MIN_DWELL=10)
      add(1, 1, 1, 0, 0, 0, 1, 0);   // edge 0: OFF -> DEAD
      add(1, 1, 3, 0, 0, 0, 1, 0);   // edges 1..3 dead
      add(1, 1, 1, 1, 0, 1, 1, 1);   // edge 4: HIGH
      add(1, 1, 9, 1, 0, 1, 1, 1);   // dwell 9
      add(1, 1, 1, 1, 0, 1, 0, 1);   // dwell 10: not busy
      add(1, 1, 10, 1, 0, 1, 0, 1);  // 20 cycles in HIGH
      add(1, 0, 1, 0, 0, 1, 1, 1);   // request low: gate_h drops same edge
      add(1, 0, 3, 0, 0, 1, 1, 1);
      add(1, 0, 1, 0, 1, 0, 1, 2);   // LOW 4 edges later
      add(1, 0, 3, 0, 1, 0, 1, 2);   // dwell 3
      add(1, 1, 6, 0, 1, 0, 1, 2);   // early request held off
      add(1, 1, 1, 0, 1, 0, 0, 2);   // dwell reaches 10
      add(1, 1, 1, 0, 0, 0, 1, 2);   // leave LOW
      add(1, 1, 3, 0, 0, 0, 1, 2);
      add(1, 1, 1, 1, 0, 1, 1, 3);   // HIGH
      add(1, 1, 2, 1, 0, 1, 1, 3);   // dwell 2
      add(0, 1, 1, 0, 0, 1, 0, 3);   // disable -> OFF
      add(1, 1, 1, 0, 0, 1, 1, 3);   // same-polarity re-entry through DEAD
      add(1, 0, 1, 0, 0, 1, 1, 3);   // sigma ignored in DEAD
      add(0, 0, 1, 0, 0, 1, 0, 3);   // disable mid-DEAD
      add(1, 1, 1, 0, 0, 1, 1, 3);   // re-enable
      add(1, 0, 3, 0, 0, 1, 1, 3);
      add(1, 0, 1, 1, 0, 1, 1, 4);   // full gap, latched target high
      bus.i_enable = 1'b0;
      bus.i_sigma  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_out("reset_state", obs, 20'h0);
      rst = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         bus.i_enable = vecs[i].en;
         bus.i_sigma  = vecs[i].sig;
         step(vecs[i].n);
         chk_out($sformatf("vec%0d", i), obs, {vecs[i].gh, vecs[i].gl, vecs[i].sg, vecs[i].bz, vecs[i].cnt});
      end
      // asynchronous reset between edges in the middle of DEAD
      bus.i_enable = 1'b0;
      step(1);
      bus.i_enable = 1'b1;
      bus.i_sigma  = 1'b0;
      step(2);
      chk_out("pre_reset_dead", obs, {1'b0, 1'b0, 1'b1, 1'b1, 16'd4});
      #2 rst = 1'b1;
      #1 chk_out("async_reset", obs, 20'h0);
      @(negedge clk);
      rst = 1'b0;
      step(1);
      chk_out("post_reset_dead", obs, {1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
      step(3);
      chk_out("post_reset_dead3", obs, {1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
      step(1);
      chk_out("post_reset_low", obs, {1'b0, 1'b1, 1'b0, 1'b1, 16'd1});
      // sigma toggling every cycle: gates exclusive, dwell and dead gaps respected
      c0 = bus.o_switch_count;
      prev = 2;
      run = 0;
      rises = 0;
      started = 0;
      for (int i = 0; i < 200; i++) begin
         bus.i_sigma = ~bus.i_sigma;
         step(1);
         chk_cond("no_overlap", !(bus.o_gate_h && bus.o_gate_l), {30'd0, bus.o_gate_h, bus.o_gate_l}, 0);
         lvl = bus.o_gate_h ? 1 : (bus.o_gate_l ? 2 : 0);
         if (lvl != prev) begin
            if (started && prev == 0) chk_cond("dead_gap", run >= 4, run, 4);
            if (started && prev != 0) chk_cond("dwell", run >= 10, run, 10);
            if (prev == 0) rises++;
            started = 1;
            run = 1;
            prev = lvl;
         end else
            run++;
      end
      delta = int'(16'(bus.o_switch_count - c0));
      chk_cond("toggle_switch_count", delta == rises, delta, rises);
      chk_cond("toggle_activity", rises >= 8, rises, 8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
